i2s_rx_frontend: RTL and testbench



---
 rtl/i2s_rx_frontend.sv | 130 +++++++++++++
 tb/tb_i2s_rx_frontend.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/i2s_rx_frontend.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA on the master clock and forwards one channel per rclk rise.
// Latency: data_out one cycle after a detected rclk edge. There is no backpressure: a missed sample raises overrun and a reused one raises underrun.
module i2s_rx_frontend #(
    parameter int WORD_W      = 24,
    parameter int SLOT_W      = 32,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     bclk_in,
    input  logic                     lrck_in,
    input  logic                     sdata_in,
    input  logic                     ch_sel,
    input  logic                     rclk_in,
    output logic signed [WORD_W-1:0] data_out,
    output logic                     locked,
    output logic                     frame_err,
    output logic                     underrun,
    output logic                     overrun
);
    localparam int BIT_W   = $clog2(WORD_W);
    localparam int SLOT_CW = $clog2(SLOT_W + 1);
    localparam int GOOD_W  = $clog2(LOCK_FRAMES + 1);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [SLOT_CW-1:0] SLOT_MAX = SLOT_CW'(SLOT_W);
    localparam logic [GOOD_W-1:0]  GOOD_MAX = GOOD_W'(LOCK_FRAMES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAD   = 2'd2;

    // BCLK and rclk carry a third history flop for edge detection; LRCK and SDATA are only sampled
    logic [2:0] bclk_s, rclk_s;
    logic [1:0] lrck_s, sdata_s;

    logic [1:0]         state;
    logic               primed, lrck_prev, chan, ch_sel_q, fresh;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SLOT_CW-1:0] slot_cnt;
    logic [GOOD_W-1:0]  good_cnt;
    logic [WORD_W-1:0]  shift_reg, hold_reg, word;
    logic               bclk_rise, rclk_rise, lr_chg, commit, commit_sel, err;

    assign bclk_rise  = bclk_s[1] & ~bclk_s[2];
    assign rclk_rise  = rclk_s[1] & ~rclk_s[2];
    assign lr_chg     = primed && (lrck_s[1] != lrck_prev);
    assign word       = {shift_reg[WORD_W-2:0], sdata_s[1]};
    assign commit     = bclk_rise && (state == SHIFT) && !lr_chg && (bit_cnt == LAST_BIT);
    assign commit_sel = commit && (chan == ch_sel);
    assign err        = bclk_rise && (((state == SHIFT) && lr_chg) ||
                                      ((state == PAD) && !lr_chg && (slot_cnt == SLOT_MAX)));
    assign locked     = (good_cnt == GOOD_MAX);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            bclk_s  <= '0;
            rclk_s  <= '0;
            lrck_s  <= '0;
            sdata_s <= '0;
        end else begin
            bclk_s  <= {bclk_s[1:0], bclk_in};
            rclk_s  <= {rclk_s[1:0], rclk_in};
            lrck_s  <= {lrck_s[0], lrck_in};
            sdata_s <= {sdata_s[0], sdata_in};
        end
    end

    // The rise on which the new LRCK level is first seen carries the I2S delay bit; capture starts on the next rise
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            primed    <= 1'b0;
            lrck_prev <= 1'b0;
            chan      <= 1'b0;
            bit_cnt   <= '0;
            slot_cnt  <= '0;
            shift_reg <= '0;
        end else if (bclk_rise) begin
            primed    <= 1'b1;
            lrck_prev <= lrck_s[1];
            if (slot_cnt != SLOT_MAX) slot_cnt <= slot_cnt + 1'b1;
            if (lr_chg) begin
                state    <= SHIFT;
                chan     <= lrck_s[1];
                bit_cnt  <= '0;
                slot_cnt <= SLOT_CW'(1);
            end else begin
                case (state)
                    SHIFT: begin
                        shift_reg <= word;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= PAD;
                    end
                    PAD: if (slot_cnt == SLOT_MAX) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            ch_sel_q  <= 1'b0;
            good_cnt  <= '0;
            hold_reg  <= '0;
            fresh     <= 1'b0;
            data_out  <= '0;
            frame_err <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            ch_sel_q  <= ch_sel;
            frame_err <= err;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
            // A channel switch needs a fresh lock on the new stream
            if (err || (ch_sel != ch_sel_q)) good_cnt <= '0;
            else if (commit_sel && !locked) good_cnt <= good_cnt + 1'b1;
            if (commit_sel) hold_reg <= word;
            if (rclk_rise) begin
                data_out <= locked ? (commit_sel ? word : hold_reg) : '0;
                underrun <= locked && !fresh && !commit_sel;
                fresh    <= 1'b0;
            end else if (commit_sel) begin
                overrun <= fresh;
                fresh   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Bench for i2s_rx_frontend: frames are built half by half and a transaction-level model predicts each rclk sample.
`timescale 1ns/1ps
module tb_i2s_rx_frontend;
    localparam int WORD_W = 24, SLOT_W = 32, LOCK_FRAMES = 4;

    logic clock = 1'b0, rstn = 1'b0, bclk_in = 1'b0, lrck_in = 1'b0, sdata_in = 1'b0;
    logic ch_sel = 1'b0, rclk_in = 1'b0;
    logic signed [WORD_W-1:0] data_out;
    logic locked, frame_err, underrun, overrun;

    always #10.173 clock = ~clock;

    i2s_rx_frontend #(.WORD_W(WORD_W), .SLOT_W(SLOT_W), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .clock(clock), .rstn(rstn), .bclk_in(bclk_in), .lrck_in(lrck_in), .sdata_in(sdata_in),
        .ch_sel(ch_sel), .rclk_in(rclk_in), .data_out(data_out), .locked(locked),
        .frame_err(frame_err), .underrun(underrun), .overrun(overrun)
    );

    int checks = 0, errors = 0;
    int m_good = 0, exp_ur = 0, exp_or = 0, exp_fe = 0, got_ur = 0, got_or = 0, got_fe = 0;
    int tick_n = 0, rclk_per = 1024, chk_at = -1;
    logic m_fresh = 1'b0, m_lr_prev = 1'b0, m_short_pend = 1'b0, ferr_prev = 1'b0;
    logic [WORD_W-1:0] m_hold = '0, exp_data = '0, ramp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample consumed by the filter: newest selected word once locked, zero otherwise
    task automatic model_rclk();
        if (m_good >= LOCK_FRAMES) begin
            exp_data = m_hold;
            if (!m_fresh) exp_ur++;
        end else exp_data = '0;
        m_fresh = 1'b0;
    endtask

    task automatic model_commit(input logic lr, input logic [WORD_W-1:0] w);
        if (lr == ch_sel) begin
            if (m_fresh) exp_or++;
            m_fresh = 1'b1;
            m_hold  = w;
            if (m_good < LOCK_FRAMES) m_good++;
        end
    endtask

    task automatic tick(input logic b, input logic l, input logic s);
        logic r;
        @(negedge clock);
        if (frame_err) got_fe++;
        if (underrun) got_ur++;
        if (overrun) got_or++;
        if (ferr_prev) check("locked_after_ferr", {31'h0, locked}, 32'h0);
        ferr_prev = frame_err;
        if (tick_n == chk_at) begin
            check("data_out", {8'h0, data_out}, {8'h0, exp_data});
            check("locked", {31'h0, locked}, {31'h0, m_good >= LOCK_FRAMES});
        end
        r = (tick_n >= 100) && (((tick_n - 100) % rclk_per) < rclk_per / 2);
        if (r && !rclk_in) begin
            model_rclk();
            chk_at = tick_n + 8;
        end
        rclk_in  = r;
        bclk_in  = b;
        lrck_in  = l;
        sdata_in = s;
        tick_n++;
    endtask

    task automatic do_reset(input logic lr, input logic s);
        rstn = 1'b0;
        m_good = 0; m_fresh = 1'b0; m_hold = '0; m_short_pend = 1'b0;
        m_lr_prev = lr;
        for (int i = 0; i < 3; i++) tick(1'b0, lr, s);
        check("rst_data", {8'h0, data_out}, 32'h0);
        check("rst_locked", {31'h0, locked}, 32'h0);
        check("rst_pulses", {29'h0, frame_err, underrun, overrun}, 32'h0);
        rstn = 1'b1;
    endtask

    // One LRCK half: slot 0 is the delay bit, slots 1..WORD_W the word MSB first, the rest random padding
    task automatic send_half(input logic lr, input int len, input logic [WORD_W-1:0] w, input int rst_slot);
        logic tracked, s;
        tracked = (lr != m_lr_prev);
        if (tracked && m_short_pend) begin
            exp_fe++;
            m_good = 0;
        end
        m_short_pend = tracked && (len <= WORD_W);
        m_lr_prev = lr;
        for (int k = 0; k < len; k++) begin
            s = (k >= 1 && k <= WORD_W) ? w[WORD_W - k] : 1'($urandom & 1);
            for (int p = 0; p < 16; p++) begin
                if (p == 8 && tracked && k == WORD_W) model_commit(lr, w);
                if (p == 4 && k == rst_slot) begin
                    do_reset(lr, s);
                    tracked = 1'b0;
                end
                tick(p >= 8, lr, s);
            end
        end
    endtask

    // mode 0: full-scale pair, 1: random words, 2: left ramp with random right
    task automatic run(input int nframes, input int per, input logic cs, input int mode,
                       input int trunc_frame, input int rst_frame);
        logic [WORD_W-1:0] lw, rw;
        rclk_per = per;
        tick_n   = 0;
        chk_at   = -1;
        if (cs != ch_sel) m_good = 0;
        ch_sel = cs;
        for (int f = 0; f < nframes; f++) begin
            if (mode == 0) begin
                lw = 24'h7FFFFF; rw = 24'h800000;
            end else if (mode == 1) begin
                lw = 24'($urandom); rw = 24'($urandom);
            end else begin
                ramp = ramp + 1'b1; lw = ramp; rw = 24'($urandom);
            end
            send_half(1'b0, (f == trunc_frame) ? 21 : SLOT_W, lw, (f == rst_frame) ? 11 : -1);
            send_half(1'b1, SLOT_W, rw, -1);
        end
        check("underrun_cnt", got_ur, exp_ur);
        check("overrun_cnt", got_or, exp_or);
        check("frame_err_cnt", got_fe, exp_fe);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        check("por_data", {8'h0, data_out}, 32'h0);
        check("por_locked", {31'h0, locked}, 32'h0);
        check("por_pulses", {29'h0, frame_err, underrun, overrun}, 32'h0);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);

        run(6, 1024, 1'b0, 0, -1, -1);
        check("left_value", {8'h0, data_out}, 32'h007FFFFF);
        run(6, 1024, 1'b1, 0, -1, -1);
        check("right_sign", {31'h0, data_out < 0}, 32'h1);
        run(7, 1024, 1'b0, 1, 1, -1);
        run(6, 512, 1'b0, 2, -1, -1);
        run(8, 2048, 1'b0, 2, -1, -1);
        run(7, 1024, 1'b0, 2, -1, 1);
        check("final_locked", {31'h0, locked}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
